// File: rtl/data_mem_ctrl_pkg.sv
// ============================================================================
// Module      : data_mem_ctrl_pkg
// Description : Shared types and defaults for the wait-state data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_ctrl_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_BASE_ADDR  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_array.sv
// ============================================================================
// Module      : data_mem_array
// Description : Single-port RAM, synchronous write, combinational read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_array #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
  end

  assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module      : data_mem_ctrl
// Description : MEM-stage data memory with WAIT_CYCLES wait states and freeze.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  freeze,
  output logic                  addr_err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WORD_WIDTH-1:0] C_BASE  = WORD_WIDTH'(BASE_ADDR);
  localparam logic [WORD_WIDTH-1:0] C_DEPTH = WORD_WIDTH'(DEPTH);
  localparam logic [CNT_W-1:0]      C_WAIT  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]      C_ONE   = CNT_W'(1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic                  r_is_store;
  logic [WORD_WIDTH-1:0] r_rd_data;
  logic                  r_addr_err;

  logic                  w_req;
  logic [WORD_WIDTH-1:0] w_index;
  logic                  w_err;
  logic                  w_commit;
  logic                  w_we;
  logic [WORD_WIDTH-1:0] w_rdata;

  assign w_req    = mem_r_en | mem_w_en;
  // Range check works on the latched address so mid-access input changes are ignored.
  assign w_index  = (r_addr - C_BASE) >> 2;
  assign w_err    = (r_addr < C_BASE) || (r_addr[1:0] != 2'b00) || (w_index >= C_DEPTH);
  assign w_commit = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_we     = w_commit && r_is_store && !w_err;

  data_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_index[IDX_W-1:0]),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_req) w_next = ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE: begin
        ready  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    freeze = w_req & ~ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_store <= 1'b0;
      r_rd_data  <= '0;
      r_addr_err <= 1'b0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_cnt      <= C_WAIT;
      r_addr     <= address;
      r_wdata    <= wr_data;
      r_is_store <= mem_w_en;
      r_addr_err <= 1'b0;
    end else if (w_commit) begin
      r_addr_err <= w_err;
      // Stores leave the last load value on rd_data.
      if (!r_is_store) begin
        r_rd_data <= w_err ? '0 : w_rdata;
      end
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign rd_data  = r_rd_data;
  assign addr_err = r_addr_err;

endmodule

`default_nettype wire
